count_match_ctrl: RTL

COUNT_MATCH_CTRL -- requirements
Module: count_match_ctrl

---
 rtl/count_match_ctrl_if.sv | 22 ++
 rtl/count_match_ctrl.sv | 103 ++++++++++
 2 files changed

// File: rtl/count_match_ctrl_if.sv
// rtl/count_match_ctrl_if.sv - request/result handshake bundle for count_match_ctrl
interface count_match_ctrl_if;
    logic       in_valid;
    logic [6:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic       out_hit;
    logic [2:0] out_count;
    logic [1:0] sel;
    logic       busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_hit, out_count, sel, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_hit, out_count, sel, busy
    );
endinterface

// File: rtl/count_match_ctrl.sv
// rtl/count_match_ctrl.sv - popcount vs stepping select matcher; COUNT_MATCH_STATS_EN adds hit/miss counters
module count_match_ctrl (
    input  logic                 clk,
    input  logic                 rst,
    count_match_ctrl_if.slave    bus
`ifdef COUNT_MATCH_STATS_EN
    ,
    output logic [7:0]           hit_cnt,
    output logic [7:0]           miss_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t     state;
    logic [6:0] vec;
    logic [1:0] sel_q;
    logic       hit_q;
    logic [2:0] cnt_q;
    logic       valid_q;
    logic [2:0] ones;
    logic       z;

    always_comb begin
        ones = 3'd0;
        for (int i = 0; i < 7; i++) begin
            ones = ones + {2'b00, vec[i]};
        end
        z = (ones == {1'b0, sel_q});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            vec     <= 7'd0;
            sel_q   <= 2'd0;
            hit_q   <= 1'b0;
            cnt_q   <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        vec   <= bus.in_data;
                        sel_q <= 2'd0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (z) begin
                        hit_q   <= 1'b1;
                        cnt_q   <= {1'b0, sel_q};
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end else if (sel_q != 2'd3) begin
                        sel_q <= sel_q + 2'd1;
                    end else begin
                        // every select missed, so the count must be 4..7
                        hit_q   <= 1'b0;
                        cnt_q   <= ones;
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        sel_q   <= 2'd0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    sel_q   <= 2'd0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // in_ready must drop with rst itself, not one edge later
    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = valid_q;
    assign bus.out_hit   = hit_q;
    assign bus.out_count = cnt_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = (state != IDLE);

`ifdef COUNT_MATCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= 8'd0;
            miss_cnt <= 8'd0;
        end else if (state == DONE && bus.out_ready) begin
            if (hit_q && hit_cnt != 8'hff) begin
                hit_cnt <= hit_cnt + 8'd1;
            end
            if (!hit_q && miss_cnt != 8'hff) begin
                miss_cnt <= miss_cnt + 8'd1;
            end
        end
    end
`endif
endmodule
